// File: rtl/gray_rx_monitor.sv
// Gray-code receive monitor: decodes a Gray count stream and checks that
// each accepted sample is a legal single step from the previous one.
//
// Ports: Clk, Reset (sync, active-low), Clear, Valid, Gray[WIDTH]
//        -> Binary[WIDTH], Step, Down, Wrap, WrapCount[WRAP_W],
//           Locked, Error. All outputs are registered.
// Optional: define GRAY_BIDIR_EN to accept -1 steps as legal down steps.
module gray_rx_monitor #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clear,
  input  logic              Valid,
  input  logic [WIDTH-1:0]  Gray,
  output logic [WIDTH-1:0]  Binary,
  output logic              Step,
  output logic              Down,
  output logic              Wrap,
  output logic [WRAP_W-1:0] WrapCount,
  output logic              Locked,
  output logic              Error
);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    FAULT
  } state_t;

  localparam logic [WIDTH-1:0]  MAXV = '1;
  localparam logic [WIDTH-1:0]  ONE  = WIDTH'(1);
  localparam logic [WRAP_W-1:0] WMAX = '1;

  state_t state, state_n;

  logic [WIDTH-1:0]  dec;
  logic [WIDTH-1:0]  delta;
  logic              is_hold;
  logic              is_up;
  logic              is_dn;
  logic              legal;

  logic [WIDTH-1:0]  bin_n;
  logic              step_n;
  logic              down_n;
  logic              wrap_n;
  logic [WRAP_W-1:0] wcnt_n;
  logic              err_n;

  // b[i] is the XOR of all Gray bits at or above i.
  always_comb begin
    dec = '0;
    for (int i = 0; i < WIDTH; i++)
      dec[i] = ^(Gray >> i);
  end

  assign delta   = dec - Binary;
  assign is_hold = (delta == '0);
  assign is_up   = (delta == ONE);
`ifdef GRAY_BIDIR_EN
  assign is_dn   = (delta == MAXV);
`else
  assign is_dn   = 1'b0;
`endif
  assign legal   = is_hold | is_up | is_dn;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= IDLE;
      Binary    <= '0;
      Step      <= 1'b0;
      Down      <= 1'b0;
      Wrap      <= 1'b0;
      WrapCount <= '0;
      Error     <= 1'b0;
    end else begin
      state     <= state_n;
      Binary    <= bin_n;
      Step      <= step_n;
      Down      <= down_n;
      Wrap      <= wrap_n;
      WrapCount <= wcnt_n;
      Error     <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    if (Clear) begin
      state_n = IDLE;
    end else if (Valid) begin
      case (state)
        IDLE:    state_n = TRACK;
        TRACK:   if (!legal) state_n = FAULT;
        default: state_n = state;
      endcase
    end
  end

  always_comb begin
    bin_n  = Binary;
    step_n = 1'b0;
    down_n = 1'b0;
    wrap_n = 1'b0;
    wcnt_n = WrapCount;
    err_n  = Error;
    if (Clear) begin
      err_n = 1'b0;
    end else if (Valid && state == IDLE) begin
      bin_n = dec;
    end else if (Valid && state == TRACK) begin
      unique case (1'b1)
        is_hold: ;
        is_up: begin
          bin_n  = dec;
          step_n = 1'b1;
          // +1 from the top code can only land on zero.
          if (Binary == MAXV) begin
            wrap_n = 1'b1;
            if (WrapCount != WMAX)
              wcnt_n = WrapCount + 1'b1;
          end
        end
        is_dn: begin
          bin_n  = dec;
          step_n = 1'b1;
          down_n = 1'b1;
          if (Binary == '0) begin
            wrap_n = 1'b1;
            if (WrapCount != '0)
              wcnt_n = WrapCount - 1'b1;
          end
        end
        default: err_n = 1'b1;
      endcase
    end
  end

  assign Locked = (state == TRACK);

endmodule

// File: tb/tb_gray_rx_monitor.sv
// Bench for gray_rx_monitor: directed Gray sequences checked every cycle
// against an integer reference model, plus literal spot checks.
module tb_gray_rx_monitor;

  localparam int W  = 3;
  localparam int WW = 2;
  localparam int TOP  = (1 << W) - 1;
  localparam int WTOP = (1 << WW) - 1;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Clear = 1'b0;
  logic          Valid = 1'b0;
  logic [W-1:0]  Gray = '0;
  logic [W-1:0]  Binary;
  logic          Step;
  logic          Down;
  logic          Wrap;
  logic [WW-1:0] WrapCount;
  logic          Locked;
  logic          Error;

  gray_rx_monitor #(.WIDTH(W), .WRAP_W(WW)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Clear(Clear),
    .Valid(Valid),
    .Gray(Gray),
    .Binary(Binary),
    .Step(Step),
    .Down(Down),
    .Wrap(Wrap),
    .WrapCount(WrapCount),
    .Locked(Locked),
    .Error(Error)
  );

  always #5 Clk = ~Clk;

  int n_run = 0;
  int n_fail = 0;
  bit run = 1'b0;

  // Model: st 0=idle, 1=tracking, 2=faulted.
  int m_bin = 0;
  int m_wc = 0;
  int m_st = 0;
  bit m_step = 1'b0;
  bit m_down = 1'b0;
  bit m_wrap = 1'b0;
  bit m_err = 1'b0;

  logic [W-1:0] fseq [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110,
                             3'b111, 3'b101, 3'b100, 3'b000};

  function automatic int g2b(input logic [W-1:0] g);
    for (int v = 0; v <= TOP; v++)
      if (W'(v ^ (v >> 1)) == g) return v;
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int v, d;
    m_step = 1'b0;
    m_down = 1'b0;
    m_wrap = 1'b0;
    if (!Reset) begin
      m_bin = 0; m_wc = 0; m_st = 0; m_err = 1'b0;
    end else if (Clear) begin
      m_st = 0; m_err = 1'b0;
    end else if (Valid) begin
      v = g2b(Gray);
      if (m_st == 0) begin
        m_bin = v; m_st = 1;
      end else if (m_st == 1) begin
        d = (v - m_bin + TOP + 1) % (TOP + 1);
        if (d == 0) begin
        end else if (d == 1) begin
          m_step = 1'b1;
          if (m_bin == TOP) begin
            m_wrap = 1'b1;
            if (m_wc < WTOP) m_wc++;
          end
          m_bin = v;
        end
`ifdef GRAY_BIDIR_EN
        else if (d == TOP) begin
          m_step = 1'b1;
          m_down = 1'b1;
          if (m_bin == 0) begin
            m_wrap = 1'b1;
            if (m_wc > 0) m_wc--;
          end
          m_bin = v;
        end
`endif
        else begin
          m_err = 1'b1; m_st = 2;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit c, input bit v,
                     input logic [W-1:0] g);
    @(negedge Clk);
    Reset = r; Clear = c; Valid = v; Gray = g;
    @(posedge Clk);
    model_step();
    run = 1'b1;
    #1;
  endtask

  always @(negedge Clk) begin
    if (run) begin
      chk("Binary", 32'(Binary), 32'(m_bin));
      chk("Step", 32'(Step), 32'(m_step));
      chk("Down", 32'(Down), 32'(m_down));
      chk("Wrap", 32'(Wrap), 32'(m_wrap));
      chk("WrapCount", 32'(WrapCount), 32'(m_wc));
      chk("Locked", 32'(Locked), 32'(m_st == 1));
      chk("Error", 32'(Error), 32'(m_err));
    end
  end

  initial begin
    cyc(1'b0, 1'b0, 1'b0, 3'b000);
    chk("rst_bin", 32'(Binary), 0);
    chk("rst_lock", 32'(Locked), 0);
    chk("rst_err", 32'(Error), 0);
    chk("rst_wc", 32'(WrapCount), 0);

    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 1'b0, 1'b1, fseq[i]);
      chk("fwd_bin", 32'(Binary), 32'(i % 8));
      chk("fwd_lock", 32'(Locked), 1);
    end
    chk("fwd_wrap", 32'(Wrap), 1);
    chk("fwd_wc", 32'(WrapCount), 1);

    for (int k = 0; k < 4; k++) begin
      for (int i = 1; i < 9; i++)
        cyc(1'b1, 1'b0, 1'b1, fseq[i]);
      chk("sat_wc", 32'(WrapCount), (k + 2 > 3) ? 3 : 32'(k + 2));
    end

    cyc(1'b1, 1'b0, 1'b1, 3'b001);
    cyc(1'b0, 1'b0, 1'b1, 3'b011);
    chk("mid_rst_bin", 32'(Binary), 0);
    chk("mid_rst_wc", 32'(WrapCount), 0);
    chk("mid_rst_lock", 32'(Locked), 0);

    cyc(1'b1, 1'b0, 1'b1, 3'b000);
    cyc(1'b1, 1'b0, 1'b1, 3'b001);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 3'b000);
    cyc(1'b1, 1'b0, 1'b1, 3'b001);
    chk("rep_step", 32'(Step), 0);
    chk("rep_bin", 32'(Binary), 1);
    cyc(1'b1, 1'b0, 1'b1, 3'b011);
    chk("gap_step", 32'(Step), 1);
    chk("gap_bin", 32'(Binary), 2);

    cyc(1'b0, 1'b0, 1'b0, 3'b000);
    cyc(1'b1, 1'b0, 1'b1, 3'b000);
    cyc(1'b1, 1'b0, 1'b1, 3'b001);
    cyc(1'b1, 1'b0, 1'b1, 3'b110);
    chk("ill_err", 32'(Error), 1);
    chk("ill_lock", 32'(Locked), 0);
    chk("ill_bin", 32'(Binary), 1);
    cyc(1'b1, 1'b0, 1'b1, 3'b011);
    cyc(1'b1, 1'b0, 1'b1, 3'b010);
    chk("flt_bin", 32'(Binary), 1);
    chk("flt_err", 32'(Error), 1);
    cyc(1'b1, 1'b1, 1'b0, 3'b000);
    chk("clr_err", 32'(Error), 0);
    chk("clr_lock", 32'(Locked), 0);
    cyc(1'b1, 1'b0, 1'b1, 3'b111);
    chk("relock", 32'(Locked), 1);
    chk("relock_bin", 32'(Binary), 5);
    chk("relock_step", 32'(Step), 0);

    cyc(1'b0, 1'b0, 1'b0, 3'b000);
    cyc(1'b1, 1'b0, 1'b1, 3'b000);
    cyc(1'b1, 1'b0, 1'b1, 3'b001);
    cyc(1'b1, 1'b0, 1'b1, 3'b011);
    cyc(1'b1, 1'b0, 1'b1, 3'b001);
`ifdef GRAY_BIDIR_EN
    chk("back_step", 32'(Step), 1);
    chk("back_down", 32'(Down), 1);
    chk("back_bin", 32'(Binary), 1);
`else
    chk("back_err", 32'(Error), 1);
    chk("back_bin", 32'(Binary), 2);
`endif
    cyc(1'b0, 1'b0, 1'b0, 3'b000);
    cyc(1'b1, 1'b0, 1'b1, 3'b000);
    cyc(1'b1, 1'b0, 1'b1, 3'b100);
`ifdef GRAY_BIDIR_EN
    chk("dwrap_wrap", 32'(Wrap), 1);
    chk("dwrap_wc", 32'(WrapCount), 0);
    chk("dwrap_bin", 32'(Binary), 7);
`else
    chk("dwrap_err", 32'(Error), 1);
`endif

    cyc(1'b1, 1'b0, 1'b1, 3'b101);
    cyc(1'b0, 1'b1, 1'b1, 3'b101);
    chk("pri_rst_bin", 32'(Binary), 0);
    chk("pri_rst_lock", 32'(Locked), 0);
    chk("pri_rst_err", 32'(Error), 0);
    cyc(1'b1, 1'b0, 1'b1, 3'b000);
    cyc(1'b1, 1'b0, 1'b1, 3'b001);
    cyc(1'b1, 1'b1, 1'b1, 3'b011);
    chk("pri_clr_lock", 32'(Locked), 0);
    chk("pri_clr_step", 32'(Step), 0);
    chk("pri_clr_bin", 32'(Binary), 1);
    cyc(1'b1, 1'b0, 1'b1, 3'b011);
    chk("pri_relock", 32'(Locked), 1);
    chk("pri_relock_bin", 32'(Binary), 2);

    @(negedge Clk);
    #1;
    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_rx_monitor.md
Name: gray_rx_monitor

Overview:
- Receiving end of the Gray-code counter interface.
- Samples a Gray-coded count stream, decodes it to binary, and checks that each new sample is a legal single step from the previous one.
- Reports step and wrap events, keeps a wrap counter, and latches a sticky error on any illegal transition.
- Sits downstream of a Gray counter, e.g. across a domain boundary after a synchroniser, or as a checker in the P1 counter benches.

Parameters:
- WIDTH, 3: Gray/binary code width in bits.
- WRAP_W, 8: width of the wrap counter.

Ports:
- Clk  input  1  clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-low reset (0 at posedge Clk = reset).
- Clear  input  1  synchronous: clear fault state and return to IDLE.
- Valid  input  1  Gray is a sample to check this cycle.
- Gray  input  WIDTH  Gray-coded count sample.
- Binary  output  WIDTH  registered decoded value of the last accepted sample.
- Step  output  1  one-cycle pulse: the last sample was a legal ±1 step.
- Down  output  1  one-cycle pulse: the step was downward. Tied 0 unless GRAY_BIDIR_EN.
- Wrap  output  1  one-cycle pulse: the step crossed the top/bottom boundary (max->0, or 0->max in bidir mode).
- WrapCount  output  WRAP_W  number of wraps, saturating.
- Locked  output  1  high while in TRACK.
- Error  output  1  sticky illegal-transition flag.

Behaviour:
- Decode: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i]. Purely combinational from Gray; all outputs are registered.
- Latency: a sample presented with Valid at edge N is reflected on the outputs after edge N (visible in cycle N+1).
- Priority at each posedge Clk: Reset low > Clear > Valid.
- Reset: Binary=0, Step=0, Down=0, Wrap=0, WrapCount=0, Locked=0, Error=0, state IDLE. Reset mid-stream discards all history, including WrapCount.
- Clear (with Reset high): state IDLE, Error=0, Locked=0, pulses=0. Binary and WrapCount are held.
- Step, Down and Wrap are 0 on every cycle not explicitly pulsed below.
- States: IDLE, TRACK, FAULT.
- IDLE:
  - Valid=1: Binary <= decode(Gray); go to TRACK; Locked=1 next cycle; no Step.
  - Valid=0: hold.
- TRACK, Valid=1: let d = decode(Gray) - Binary, computed mod 2^WIDTH.
  - d==0: hold Binary; no pulse. A repeated sample is legal.
  - d==1: Binary <= new value; Step=1. If old==2^WIDTH-1 and new==0, also Wrap=1 and WrapCount+1, saturating at 2^WRAP_W-1.
  - d==2^WIDTH-1:
    - With GRAY_BIDIR_EN: see Optional Feature.
    - Without it: treated as illegal.
  - Any other d: Error=1; go to FAULT; Locked=0; Binary holds the last good value; no Step.
- TRACK, Valid=0: hold everything; pulses 0.
- FAULT:
  - Valid is ignored; Binary, WrapCount and Error hold.
  - Exited only by Clear or Reset.
- Gray input is not checked for Hamming distance directly. The legality test is the modular binary delta only, which is equivalent for a valid Gray stream.
- Illegal encodings do not exist: every WIDTH-bit value decodes.

Optional Feature:
- Macro: GRAY_BIDIR_EN.
- Defined:
  - d==2^WIDTH-1 is a legal down step: Binary updated, Step=1, Down=1.
  - If old==0 and new==2^WIDTH-1: Wrap=1 and WrapCount-1, saturating at 0.
- Undefined:
  - d==2^WIDTH-1 sets Error and enters FAULT like any other illegal jump.
  - Down is constant 0.

Test Plan:
- Full forward cycle:
  - Stimulus: Reset low 1 cycle, then Valid every cycle with Gray 000,001,011,010,110,111,101,100,000.
  - Response: Binary 0,1,...,7,0. Locked=1 from the cycle after the first sample. Step=1 on every sample after the first. Wrap=1 only on the final 100->000 step. WrapCount=1. Error=0 throughout.
- Repeat and gaps:
  - Stimulus: 000,001, then Valid=0 for 3 cycles, then 001,011.
  - Response: Binary stays 1 with Step=0 during the gap and on the repeated 001. Step=1 and Binary=2 on 011.
- Illegal jump:
  - Stimulus: 000,001, then 110 (binary 1->4).
  - Response: Error=1, Locked=0, Binary=1 held.
  - Follow-up: further Valid samples change nothing. Clear for 1 cycle gives Error=0, Locked=0, IDLE; the next sample relocks.
- Backward step:
  - Stimulus: 000,001,011, then 001.
  - Without GRAY_BIDIR_EN: Error=1, FAULT.
  - With GRAY_BIDIR_EN: Step=1, Down=1, Binary=1.
  - With GRAY_BIDIR_EN, 000 then 100: Wrap=1, WrapCount stays 0 (saturation at 0).
- Saturation and reset:
  - Stimulus: WRAP_W=2, 5 full forward cycles.
  - Response: WrapCount 1,2,3,3,3.
  - Follow-up: Reset low mid-sequence returns all outputs to 0 and the block to IDLE after that edge.
- Priority:
  - Stimulus: Reset low together with Clear=1 and Valid=1 on one edge.
  - Response: reset values, state IDLE.
  - Stimulus: Clear=1 with a legal Valid in TRACK.
  - Response: IDLE, no Step, Binary held.
